mem_arbiter: RTL and testbench

- Shares one external memory port between instruction fetch (icache side) and data access (dcache side) of the 5-stage pipeline.
- Sits between the pipeline's icache_*/dcache_* ports and the single memory/bus master port.
- Uses round-robin arbitration with a grant-holding FSM.
- The waitrequest handshake is passed through per requester; the non-granted requester is stalled.

---
 rtl/mem_arb_pkg.sv | 36 +++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for mem_arbiter: FSM states, requester identity, reset grant history
// and the round-robin pick helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } arb_req_t;

    // Fetch is treated as the previous winner so data wins the first contention.
    localparam arb_req_t RESET_LAST_GRANT = REQ_I;

    // Round-robin pick from idle: a lone requester wins, a tie goes to whoever did not win last.
    function automatic arb_state_t pick_grant(input logic i_req, input logic d_req,
                                              input arb_req_t last_grant);
        arb_state_t next_state;
        next_state = ARB_IDLE;
        if (i_req && d_req) begin
            next_state = (last_grant == REQ_I) ? ARB_GRANT_D : ARB_GRANT_I;
        end else if (i_req) begin
            next_state = ARB_GRANT_I;
        end else if (d_req) begin
            next_state = ARB_GRANT_D;
        end else begin
            next_state = ARB_IDLE;
        end
        return next_state;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory master port between fetch and data access.
// Optional grant watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] i_data,
    output logic                  i_waitrequest,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_rd,
    input  logic                  d_wr,
    input  logic [DATA_WIDTH-1:0] d_wr_data,
    output logic [DATA_WIDTH-1:0] d_data,
    output logic                  d_waitrequest,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_rd,
    output logic                  m_wr,
    output logic [DATA_WIDTH-1:0] m_wr_data,
    input  logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_waitrequest,
    output logic                  arb_timeout
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t state_q, state_d;
    arb_req_t   last_grant_q, last_grant_d;

    // Read data is broadcast; each requester only samples it when its own waitrequest drops.
    assign i_data = m_data;
    assign d_data = m_data;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Stall counter: zero while idle so every grant starts fresh, counts stalled granted cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ARB_IDLE) begin
            cnt_d = '0;
        end else if (m_waitrequest) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign arb_timeout = 1'b0;
`endif

    // Next-state, grant history and master-port mux.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        m_addr        = '0;
        m_rd          = 1'b0;
        m_wr          = 1'b0;
        m_wr_data     = '0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        arb_timeout   = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                state_d = pick_grant(i_rd, d_rd | d_wr, last_grant_q);
            end
            ARB_GRANT_I: begin
                m_addr        = i_addr;
                m_rd          = i_rd;
                i_waitrequest = m_waitrequest;
                if (!i_rd) begin
                    state_d = ARB_IDLE;
                end else if (!m_waitrequest) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = REQ_I;
                end else begin
                    state_d = ARB_GRANT_I;
                end
            end
            ARB_GRANT_D: begin
                // A simultaneous read and write is issued as the write.
                m_addr        = d_addr;
                m_wr          = d_wr;
                m_rd          = d_rd & ~d_wr;
                m_wr_data     = d_wr_data;
                d_waitrequest = m_waitrequest;
                if (!(d_rd | d_wr)) begin
                    state_d = ARB_IDLE;
                end else if (!m_waitrequest) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = REQ_D;
                end else begin
                    state_d = ARB_GRANT_D;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog expiry releases the requester with undefined data and kills the bus cycle.
        if ((state_q != ARB_IDLE) && m_waitrequest && (m_rd | m_wr) && (cnt_q == CNT_LAST)) begin
            arb_timeout = 1'b1;
            m_rd        = 1'b0;
            m_wr        = 1'b0;
            state_d     = ARB_IDLE;
            if (state_q == ARB_GRANT_I) begin
                i_waitrequest = 1'b0;
                last_grant_d  = REQ_I;
            end else begin
                d_waitrequest = 1'b0;
                last_grant_d  = REQ_D;
            end
        end else begin
            arb_timeout = 1'b0;
        end
`endif
    end

    // FSM state and grant history registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= RESET_LAST_GRANT;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the watchdog section follows MEM_ARB_TIMEOUT_EN.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic [31:0] i_addr;
    logic        i_rd;
    logic [31:0] i_data;
    logic        i_waitrequest;
    logic [31:0] d_addr;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_wr_data;
    logic [31:0] d_data;
    logic        d_waitrequest;
    logic [31:0] m_addr;
    logic        m_rd;
    logic        m_wr;
    logic [31:0] m_wr_data;
    logic [31:0] m_data;
    logic        m_waitrequest;
    logic        arb_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .i_addr       (i_addr),
        .i_rd         (i_rd),
        .i_data       (i_data),
        .i_waitrequest(i_waitrequest),
        .d_addr       (d_addr),
        .d_rd         (d_rd),
        .d_wr         (d_wr),
        .d_wr_data    (d_wr_data),
        .d_data       (d_data),
        .d_waitrequest(d_waitrequest),
        .m_addr       (m_addr),
        .m_rd         (m_rd),
        .m_wr         (m_wr),
        .m_wr_data    (m_wr_data),
        .m_data       (m_data),
        .m_waitrequest(m_waitrequest),
        .arb_timeout  (arb_timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance into the next cycle, clear of the rising edge.
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, "_m_rd"}, m_rd, 1'b0);
        chk1({tag, "_m_wr"}, m_wr, 1'b0);
        chk1({tag, "_i_wait"}, i_waitrequest, 1'b1);
        chk1({tag, "_d_wait"}, d_waitrequest, 1'b1);
    endtask

    initial begin
        reset = 1'b1; i_addr = 32'h0; i_rd = 1'b0; d_addr = 32'h0; d_rd = 1'b0; d_wr = 1'b0;
        d_wr_data = 32'h0; m_data = 32'h0; m_waitrequest = 1'b0;
        cyc(); cyc(); #1;
        chk_idle("reset");
        chk1("reset_timeout", arb_timeout, 1'b0);
        chk32("reset_m_addr", m_addr, 32'h0);
        chk32("reset_m_wr_data", m_wr_data, 32'h0);

        // Fetch read
        cyc(); reset = 1'b0; i_rd = 1'b1; i_addr = 32'h100; m_data = 32'h12345678; #1;
        chk1("fetch_c1_m_rd", m_rd, 1'b0);
        cyc(); #1;
        chk1("fetch_c2_m_rd", m_rd, 1'b1);
        chk32("fetch_c2_m_addr", m_addr, 32'h100);
        chk1("fetch_c2_i_wait", i_waitrequest, 1'b0);
        chk32("fetch_c2_i_data", i_data, 32'h12345678);
        chk1("fetch_c2_d_wait", d_waitrequest, 1'b1);
        cyc(); i_rd = 1'b0; #1;
        chk_idle("fetch_c3");

        // Contention after reset: data first, one idle cycle, then fetch
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0; i_rd = 1'b1; i_addr = 32'h200; d_rd = 1'b1; d_addr = 32'h300; #1;
        chk1("cont_c0_m_rd", m_rd, 1'b0);
        cyc(); #1;
        chk32("cont_d_m_addr", m_addr, 32'h300);
        chk1("cont_d_d_wait", d_waitrequest, 1'b0);
        chk1("cont_d_i_wait", i_waitrequest, 1'b1);
        cyc(); d_rd = 1'b0; #1;
        chk_idle("cont_turn");
        cyc(); #1;
        chk32("cont_i_m_addr", m_addr, 32'h200);
        chk1("cont_i_i_wait", i_waitrequest, 1'b0);
        cyc(); i_rd = 1'b0; #1;
        chk1("cont_end_m_rd", m_rd, 1'b0);

        // Sustained contention: D, I, D, I with idle turnarounds
        cyc(); i_rd = 1'b1; i_addr = 32'h210; d_rd = 1'b1; d_addr = 32'h310; #1;
        chk1("sus_idle0", m_rd, 1'b0);
        cyc(); #1; chk32("sus_g1_D", m_addr, 32'h310);
        cyc(); #1; chk1("sus_idle1", m_rd, 1'b0);
        cyc(); #1; chk32("sus_g2_I", m_addr, 32'h210);
        cyc(); #1; chk1("sus_idle2", m_rd, 1'b0);
        cyc(); #1; chk32("sus_g3_D", m_addr, 32'h310);
        cyc(); #1; chk1("sus_idle3", m_rd, 1'b0);
        cyc(); #1; chk32("sus_g4_I", m_addr, 32'h210);
        chk1("sus_g4_d_wait", d_waitrequest, 1'b1);
        cyc(); i_rd = 1'b0; d_rd = 1'b0; #1;
        chk_idle("sus_end");

        // Stalled write, with d_rd also set so the write must win
        cyc(); d_wr = 1'b1; d_rd = 1'b1; d_addr = 32'h40; d_wr_data = 32'hCAFEF00D; m_waitrequest = 1'b1; #1;
        chk1("wr_idle_m_wr", m_wr, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk1("wr_stall_m_wr", m_wr, 1'b1);
            chk1("wr_stall_m_rd", m_rd, 1'b0);
            chk32("wr_stall_data", m_wr_data, 32'hCAFEF00D);
            chk32("wr_stall_addr", m_addr, 32'h40);
            chk1("wr_stall_d_wait", d_waitrequest, 1'b1);
        end
        cyc(); m_waitrequest = 1'b0; #1;
        chk1("wr_done_m_wr", m_wr, 1'b1);
        chk32("wr_done_data", m_wr_data, 32'hCAFEF00D);
        chk1("wr_done_d_wait", d_waitrequest, 1'b0);
        cyc(); d_wr = 1'b0; d_rd = 1'b0; #1;
        chk_idle("wr_end");
        chk32("wr_end_m_wr_data", m_wr_data, 32'h0);

        // Reset mid-grant (last grant was D; reset must restore I so D wins again)
        cyc(); d_rd = 1'b1; d_addr = 32'h44; m_waitrequest = 1'b1; #1;
        cyc(); #1;
        chk1("rstmid_grant_m_rd", m_rd, 1'b1);
        cyc(); reset = 1'b1; #1;
        chk1("rstmid_still_m_rd", m_rd, 1'b1);
        cyc(); reset = 1'b0; d_rd = 1'b0; m_waitrequest = 1'b0; #1;
        chk_idle("rstmid_after");
        cyc(); i_rd = 1'b1; i_addr = 32'h500; d_rd = 1'b1; d_addr = 32'h600; #1;
        chk1("rstmid_idle_m_rd", m_rd, 1'b0);
        cyc(); #1;
        chk32("rstmid_first_D", m_addr, 32'h600);
        cyc(); i_rd = 1'b0; d_rd = 1'b0; #1;
        chk_idle("rstmid_end");

        // Abort: fetch drops request while granted; last grant (D) must be kept
        cyc(); i_rd = 1'b1; i_addr = 32'h700; m_waitrequest = 1'b1; #1;
        cyc(); #1;
        chk1("abort_grant_m_rd", m_rd, 1'b1);
        chk1("abort_grant_i_wait", i_waitrequest, 1'b1);
        cyc(); i_rd = 1'b0; #1;
        chk1("abort_drop_m_rd", m_rd, 1'b0);
        cyc(); i_rd = 1'b1; d_rd = 1'b1; d_addr = 32'h800; m_waitrequest = 1'b0; #1;
        chk_idle("abort_idle");
        cyc(); #1;
        chk32("abort_next_I", m_addr, 32'h700);
        cyc(); i_rd = 1'b0; d_rd = 1'b0; #1;
        chk_idle("abort_end");

        // Watchdog with fetch stuck behind m_waitrequest
        cyc(); i_rd = 1'b1; i_addr = 32'h900; m_waitrequest = 1'b1; #1;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int k = 1; k <= 7; k++) begin
            cyc(); #1;
            chk1("wd_stall_timeout", arb_timeout, 1'b0);
            chk1("wd_stall_m_rd", m_rd, 1'b1);
            chk1("wd_stall_i_wait", i_waitrequest, 1'b1);
        end
        cyc(); #1;
        chk1("wd_fire_timeout", arb_timeout, 1'b1);
        chk1("wd_fire_i_wait", i_waitrequest, 1'b0);
        chk1("wd_fire_m_rd", m_rd, 1'b0);
        cyc(); i_rd = 1'b0; #1;
        chk_idle("wd_after");
        chk1("wd_after_timeout", arb_timeout, 1'b0);
`else
        for (int k = 1; k <= 12; k++) begin
            cyc(); #1;
            chk1("nowd_timeout", arb_timeout, 1'b0);
            chk1("nowd_m_rd", m_rd, 1'b1);
            chk1("nowd_i_wait", i_waitrequest, 1'b1);
        end
        cyc(); m_waitrequest = 1'b0; m_data = 32'hA5A5_5A5A; #1;
        chk1("nowd_done_i_wait", i_waitrequest, 1'b0);
        chk32("nowd_done_i_data", i_data, 32'hA5A5_5A5A);
        cyc(); i_rd = 1'b0; #1;
        chk_idle("nowd_end");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
